// File: rtl/pixel_unpacker.sv
// pixel_unpacker
//   Splits 32-bit words from the DDR-reader FIFO into two 16-bit RGB565
//   pixels. The low half is emitted first and the high half second. The
//   block tracks the raster position (x, y) of each outgoing pixel and
//   counts completed frames.
//
// Optional feature macro: PIXEL_UNPACKER_RGB888_EN
//   defined   : each pixel is widened to RGB888 by repeating the top bits of
//               each colour field into its low bits
//   undefined : out_data = {8'h00, rgb565}
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        asynchronous reset, active low
//   in_bits    packed word, two RGB565 pixels ([15:0] first, [31:16] second)
//   in_valid   in_bits is valid
//   in_ready   the block accepts in_bits this cycle
//   out_data   24-bit pixel
//   out_valid  out_data is valid
//   out_ready  downstream accepts the pixel
//   out_sof    current pixel is (0,0); qualified by out_valid
//   out_eol    current pixel is x=WIDTH-1; qualified by out_valid
//   frame_cnt  number of completed frames (wraps at 16 bits)
module pixel_unpacker #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_bits,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [23:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sof,
  output logic        out_eol,
  output logic [15:0] frame_cnt
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  typedef enum logic [1:0] {EMPTY, LO, HI} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          load;
  logic          pix_xfer;
  logic [31:0]   word_q;
  logic [15:0]   half;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= state_nxt;
  end

  // In HI the next word may be taken in the same cycle the current pixel
  // leaves, which is what keeps a sustained stream at one pixel per cycle.
  // in_ready is forced low while reset is held, even though the state
  // register already sits in EMPTY.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    case (state)
      EMPTY: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = LO;
        end
      end
      LO: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = HI;
      end
      HI: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            load      = 1'b1;
            state_nxt = LO;
          end else begin
            state_nxt = EMPTY;
          end
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (!rst) begin
      in_ready = 1'b0;
      load     = 1'b0;
    end
  end

  assign pix_xfer = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      word_q <= 32'h0;
    else if (load) word_q <= in_bits;
  end

  // Raster position of the pixel currently presented on out_data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q       <= '0;
      y_q       <= '0;
      frame_cnt <= 16'h0;
    end else if (pix_xfer) begin
      if (x_q == X_LAST) begin
        x_q <= '0;
        if (y_q == Y_LAST) begin
          y_q       <= '0;
          frame_cnt <= frame_cnt + 16'h1;
        end else begin
          y_q <= y_q + 1'b1;
        end
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  // The held word is cleared by reset, so out_data reads 0 during reset.
  assign half = (state == HI) ? word_q[31:16] : word_q[15:0];

`ifdef PIXEL_UNPACKER_RGB888_EN
  assign out_data = {half[15:11], half[15:13],
                     half[10:5],  half[10:9],
                     half[4:0],   half[4:2]};
`else
  assign out_data = {8'h00, half};
`endif

  assign out_sof = out_valid && (x_q == '0) && (y_q == '0);
  assign out_eol = out_valid && (x_q == X_LAST);

endmodule

// File: tb/tb_pixel_unpacker.sv
// tb_pixel_unpacker
//   Self-checking bench for pixel_unpacker, built with a small raster so
//   that several whole frames fit in a short run. Expected pixels are
//   queued when a word is accepted and compared when the DUT hands a
//   pixel over; a raster model predicts out_sof, out_eol and frame_cnt.
module tb_pixel_unpacker;

  localparam int W = 16;
  localparam int H = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_bits = 32'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sof;
  logic        out_eol;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_q[$];
  int          mx = 0;
  int          my = 0;
  int          mframe = 0;
  int          cyc = 0;
  int          pops = 0;
  int          first_pop = -1;
  int          last_pop = 0;
  logic        toggle_en = 1'b0;
  logic        stall_prev = 1'b0;
  logic [23:0] stall_data;
  logic        stall_sof;
  logic        stall_eol;

  typedef struct {
    logic [31:0] word;
    logic [23:0] exp_lo;
    logic [23:0] exp_hi;
  } vec_t;

  vec_t tbl[4];

  pixel_unpacker #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_bits  (in_bits),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sof  (out_sof),
    .out_eol  (out_eol),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Reference colour conversion for one RGB565 half.
  function automatic logic [23:0] expand(input logic [15:0] h);
`ifdef PIXEL_UNPACKER_RGB888_EN
    return {h[15:11], h[15:13], h[10:5], h[10:9], h[4:0], h[4:2]};
`else
    return {8'h00, h};
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Offers one word and queues its two pixels once it is accepted.
  // Returns one step after the accepting edge with in_valid still high,
  // so back-to-back calls form a sustained stream.
  task automatic applyStimulus(input logic [31:0] w, input logic [23:0] elo,
                               input logic [23:0] ehi);
    bit ok;
    ok = 0;
    in_bits  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        exp_q.push_back(elo);
        exp_q.push_back(ehi);
        ok = 1;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: word 0x%0h not accepted in 50 cycles", w);
      in_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    bit done;
    done = 0;
    in_valid = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0) done = 1;
    end
    checkOutput("drain_queue_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (toggle_en) out_ready = ~out_ready;
    end
  end

  // Monitor: looks at the DUT at the falling edge; a pixel seen with
  // out_valid && out_ready there transfers on the next rising edge.
  initial begin
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        stall_prev = 1'b0;
      end else if (out_valid === 1'b1) begin
        if (stall_prev) begin
          checkOutput("stall_data_stable", out_data, stall_data);
          checkOutput("stall_sof_stable", out_sof, stall_sof);
          checkOutput("stall_eol_stable", out_eol, stall_eol);
        end
        if (out_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_pixel: got 0x%0h with nothing expected", out_data);
          end else begin
            e = exp_q.pop_front();
            checkOutput("pixel_data", out_data, e);
          end
          checkOutput("sof", out_sof, (mx == 0 && my == 0));
          checkOutput("eol", out_eol, (mx == W - 1));
          checkOutput("frame_cnt", frame_cnt, mframe);
          if (mx == W - 1) begin
            mx = 0;
            if (my == H - 1) begin
              my = 0;
              mframe = (mframe + 1) & 16'hFFFF;
            end else begin
              my++;
            end
          end else begin
            mx++;
          end
          pops++;
          if (first_pop < 0) first_pop = cyc;
          last_pop = cyc;
          stall_prev = 1'b0;
        end else begin
          stall_prev = 1'b1;
          stall_data = out_data;
          stall_sof  = out_sof;
          stall_eol  = out_eol;
        end
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
`ifdef PIXEL_UNPACKER_RGB888_EN
    tbl[0] = '{32'h07E0F800, 24'hFF0000, 24'h00FF00};
    tbl[1] = '{32'h001FFFFF, 24'hFFFFFF, 24'h0000FF};
    tbl[2] = '{32'hBEEF1234, 24'h1045A5, 24'hBDDF7B};
    tbl[3] = '{32'h00000000, 24'h000000, 24'h000000};
`else
    tbl[0] = '{32'h07E0F800, 24'h00F800, 24'h0007E0};
    tbl[1] = '{32'h001FFFFF, 24'h00FFFF, 24'h00001F};
    tbl[2] = '{32'hBEEF1234, 24'h001234, 24'h00BEEF};
    tbl[3] = '{32'h00000000, 24'h000000, 24'h000000};
`endif

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_sof", out_sof, 0);
    checkOutput("rst_out_eol", out_eol, 0);
    checkOutput("rst_frame_cnt", frame_cnt, 0);
    rst = 1'b1;
    #1;
    checkOutput("release_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Single word: one-cycle latency, low half first, in_ready low in LO.
    $display("[TB] single word");
    out_ready = 1'b1;
    applyStimulus(32'hBEEF1234, expand(16'h1234), expand(16'hBEEF));
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("lo_out_valid", out_valid, 1);
    checkOutput("lo_in_ready", in_ready, 0);
    checkOutput("lo_out_sof", out_sof, 1);
    drain();

    // Table vectors as a back-to-back stream.
    $display("[TB] table vectors");
    for (int i = 0; i < 4; i++) applyStimulus(tbl[i].word, tbl[i].exp_lo, tbl[i].exp_hi);
    drain();

    // Sustained stream crossing two frame boundaries at full rate.
    $display("[TB] sustained stream");
    pops = 0;
    first_pop = -1;
    for (int i = 0; i < 43; i++) begin
      logic [31:0] w;
      w = $urandom;
      applyStimulus(w, expand(w[15:0]), expand(w[31:16]));
    end
    drain();
    checkOutput("stream_pixel_count", pops, 86);
    checkOutput("stream_one_per_cycle", last_pop - first_pop, pops - 1);
    checkOutput("stream_frame_total", frame_cnt, 2);

    // out_ready toggling every cycle with random input gaps.
    $display("[TB] toggled out_ready");
    toggle_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      logic [31:0] w;
      w = $urandom;
      idle($urandom_range(0, 2));
      applyStimulus(w, expand(w[15:0]), expand(w[31:16]));
    end
    drain();
    toggle_en = 1'b0;
    out_ready = 1'b1;
    checkOutput("frame_total_after_toggle", frame_cnt, mframe);

    // Reset mid-frame with a word held but not yet emitted.
    $display("[TB] reset mid-frame");
    out_ready = 1'b0;
    applyStimulus(32'h11112222, expand(16'h2222), expand(16'h1111));
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    mx = 0;
    my = 0;
    mframe = 0;
    @(negedge clk);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_out_data", out_data, 0);
    checkOutput("midrst_out_sof", out_sof, 0);
    checkOutput("midrst_in_ready", in_ready, 0);
    checkOutput("midrst_frame_cnt", frame_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_release_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(32'hCAFE5A5A, expand(16'h5A5A), expand(16'hCAFE));
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("midrst_first_sof", out_sof, 1);
    checkOutput("midrst_first_data", out_data, expand(16'h5A5A));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
